// File: rtl/shift_link_pkg.sv
// Shared types and helpers for the shift-register serial link (transmitter and receiver).
package shift_link_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } link_state_e;

   // Bit-counter width for a DW-bit word; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned dw);
      return (dw < 2) ? 1 : int'($clog2(dw));
   endfunction

endpackage

// File: rtl/shift_deser_rx_if.sv
// Serial-in / parallel-out bundle for shift_deser_rx: serial strobe side plus word handshake.
interface shift_deser_rx_if #(
   parameter int unsigned DW = 4
);
   logic          en;
   logic          sync;
   logic          sdata;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          dout_ready;
   logic          overrun;
   logic          overrun_clr;
   logic          busy;

   modport master (
      output en, sync, sdata, dout_ready, overrun_clr,
      input  dout, dout_valid, overrun, busy
   );

   modport slave (
      input  en, sync, sdata, dout_ready, overrun_clr,
      output dout, dout_valid, overrun, busy
   );
endinterface

// File: rtl/shift_deser_outreg.sv
// Output holding stage: registered dout/dout_valid with valid/ready handshake and sticky overrun.
module shift_deser_outreg #(
   parameter int unsigned DW = 4
) (
   input  logic          clk,
   input  logic          async_rst,
   input  logic          word_done,
   input  logic [DW-1:0] word,
   input  logic          dout_ready,
   input  logic          overrun_clr,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   output logic          overrun
);

   logic [DW-1:0] dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          ovr_q, ovr_d;

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      // A new word always wins over a transfer; the consumer then sees it next.
      if (word_done) begin
         dout_d  = word;
         valid_d = 1'b1;
      end else if (valid_q && dout_ready) begin
         valid_d = 1'b0;
      end
      if (word_done && valid_q && !dout_ready) begin
         ovr_d = 1'b1;
      end else if (overrun_clr) begin
         ovr_d = 1'b0;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign overrun    = ovr_q;

endmodule

// File: rtl/shift_deser_rx.sv
// Serial-to-parallel receiver, MSB first; define SHIFT_DESER_LSB_FIRST_EN for LSB-first capture.
module shift_deser_rx #(
   parameter int unsigned DW = 4
) (
   input  logic            clk,
   input  logic            async_rst,
   shift_deser_rx_if.slave bus
);
   import shift_link_pkg::*;

   localparam int unsigned    CNT_W    = cnt_width(DW);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);

   link_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    sh_q, sh_d, sh_shift;
   logic             capture, restart, word_done;

   // FSM state register
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: alignment is only ever acquired, never lost short of reset
   always_comb begin
      state_d = state_q;
      if (bus.en && bus.sync) begin
         state_d = SHIFT;
      end
   end

   // FSM outputs
   always_comb begin
      capture = 1'b0;
      restart = 1'b0;
      if (bus.en) begin
         restart = bus.sync;
         capture = bus.sync || (state_q == SHIFT);
      end
   end

`ifdef SHIFT_DESER_LSB_FIRST_EN
   assign sh_shift = {bus.sdata, sh_q[DW-1:1]};
`else
   assign sh_shift = {sh_q[DW-2:0], bus.sdata};
`endif

   // Stale bits left by a restart are shifted out before the word completes.
   always_comb begin
      sh_d      = capture ? sh_shift : sh_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      if (restart) begin
         cnt_d = CNT_W'(1);
      end else if (capture) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            word_done = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
      end
   end

   shift_deser_outreg #(
      .DW (DW)
   ) u_outreg (
      .clk         (clk),
      .async_rst   (async_rst),
      .word_done   (word_done),
      .word        (sh_shift),
      .dout_ready  (bus.dout_ready),
      .overrun_clr (bus.overrun_clr),
      .dout        (bus.dout),
      .dout_valid  (bus.dout_valid),
      .overrun     (bus.overrun)
   );

   assign bus.busy = (cnt_q != '0);

endmodule

// File: tb/tb_shift_deser_rx.sv
// Self-checking bench for shift_deser_rx (DW=4) with a queue-based reference model.
module tb_shift_deser_rx;

   localparam int unsigned DW = 4;

`ifdef SHIFT_DESER_LSB_FIRST_EN
   localparam logic [3:0] W_1011 = 4'b1101;
   localparam logic [3:0] W_1100 = 4'b0011;
   localparam logic [3:0] W_0110 = 4'b0110;
   localparam logic [3:0] W_0101 = 4'b1010;
`else
   localparam logic [3:0] W_1011 = 4'b1011;
   localparam logic [3:0] W_1100 = 4'b1100;
   localparam logic [3:0] W_0110 = 4'b0110;
   localparam logic [3:0] W_0101 = 4'b0101;
`endif

   logic clk;
   logic async_rst;
   int   n_cmp;
   int   n_fail;

   shift_deser_rx_if #(.DW(DW)) bus ();

   shift_deser_rx #(
      .DW (DW)
   ) dut (
      .clk       (clk),
      .async_rst (async_rst),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: received bits since alignment, plus the output holding stage.
   bit       mq[$];
   bit       m_aligned;
   bit [3:0] m_dout;
   bit       m_valid;
   bit       m_ovr;

   task automatic model_clear();
      mq.delete();
      m_aligned = 1'b0;
      m_dout    = '0;
      m_valid   = 1'b0;
      m_ovr     = 1'b0;
   endtask

   task automatic model_step(input bit en, input bit sync, input bit sd, input bit rdy,
                             input bit clr);
      bit       done;
      bit       set_ovr;
      bit [3:0] word;
      done = 1'b0;
      word = '0;
      if (en) begin
         if (sync) begin
            mq.delete();
            mq.push_back(sd);
            m_aligned = 1'b1;
         end else if (m_aligned) begin
            mq.push_back(sd);
         end
         if (mq.size() == DW) begin
            for (int i = 0; i < int'(DW); i++) begin
`ifdef SHIFT_DESER_LSB_FIRST_EN
               word[i] = mq[i];
`else
               word[DW-1-i] = mq[i];
`endif
            end
            done = 1'b1;
            mq.delete();
         end
      end
      set_ovr = done && m_valid && !rdy;
      if (done) begin
         m_dout  = word;
         m_valid = 1'b1;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
   endtask

   task automatic cycle(input bit en, input bit sync, input bit sd, input bit rdy,
                        input bit clr);
      bus.en          = en;
      bus.sync        = sync;
      bus.sdata       = sd;
      bus.dout_ready  = rdy;
      bus.overrun_clr = clr;
      @(posedge clk);
      model_step(en, sync, sd, rdy, clr);
      #1;
   endtask

   task automatic do_reset();
      bus.en          = 1'b0;
      bus.sync        = 1'b0;
      bus.sdata       = 1'b0;
      bus.dout_ready  = 1'b0;
      bus.overrun_clr = 1'b0;
      async_rst       = 1'b1;
      #3;
      model_clear();
      async_rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (bus.dout !== 4'b0000 || bus.dout_valid !== 1'b0 || bus.overrun !== 1'b0 ||
          bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: got dout=%b valid=%b ovr=%b busy=%b, expected all 0",
                  bus.dout, bus.dout_valid, bus.overrun, bus.busy);
      end
   endtask

   task automatic test_idle_ignore();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
         n_cmp++;
         if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore[%0d]: got valid=%b busy=%b, expected 0 0",
                     i, bus.dout_valid, bus.busy);
         end
      end
   endtask

   task automatic test_single_word();
      do_reset();
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_partial: got valid=%b busy=%b, expected 0 1",
                  bus.dout_valid, bus.busy);
      end
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== W_1011 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_word: got valid=%b dout=%b busy=%b, expected 1 %b 0",
                  bus.dout_valid, bus.dout, bus.busy, W_1011);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (bus.dout_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_one_cycle: got valid=%b, expected 0", bus.dout_valid);
      end
   endtask

   task automatic test_back_to_back(input bit rdy);
      bit b[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, i == 0, b[i], rdy, 1'b0);
         if (i == 3) begin
            n_cmp++;
            if (bus.dout_valid !== 1'b1 || bus.dout !== W_1100 || bus.overrun !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_word1(rdy=%0d): got valid=%b dout=%b ovr=%b, expected 1 %b 0",
                        rdy, bus.dout_valid, bus.dout, bus.overrun, W_1100);
            end
         end else if (i > 3 && i < 7 && rdy) begin
            n_cmp++;
            if (bus.dout_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_gap[%0d]: got valid=%b, expected 0", i, bus.dout_valid);
            end
         end
      end
      n_cmp++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== W_0110 || bus.overrun !== !rdy) begin
         n_fail++;
         $display("FAIL b2b_word2(rdy=%0d): got valid=%b dout=%b ovr=%b, expected 1 %b %b",
                  rdy, bus.dout_valid, bus.dout, bus.overrun, W_0110, !rdy);
      end
      if (!rdy) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         n_cmp++;
         if (bus.overrun !== 1'b0 || bus.dout_valid !== 1'b1 || bus.dout !== W_0110) begin
            n_fail++;
            $display("FAIL overrun_clr: got ovr=%b valid=%b dout=%b, expected 0 1 %b",
                     bus.overrun, bus.dout_valid, bus.dout, W_0110);
         end
      end
   endtask

   task automatic test_resync(input bit gaps);
      bit b[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      bit s[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         if (gaps) begin
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
               cycle(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
            end
         end
         cycle(1'b1, s[i], b[i], 1'b1, 1'b0);
         if (i < 5) begin
            n_cmp++;
            if (bus.dout_valid !== 1'b0 || bus.busy !== m_valid ^ m_valid ^ (mq.size() != 0)) begin
               n_fail++;
               $display("FAIL resync_partial[%0d] gaps=%0d: got valid=%b busy=%b, expected 0 %b",
                        i, gaps, bus.dout_valid, bus.busy, mq.size() != 0);
            end
         end
      end
      n_cmp++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== W_0101 || bus.overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL resync_word gaps=%0d: got valid=%b dout=%b ovr=%b, expected 1 %b 0",
                  gaps, bus.dout_valid, bus.dout, bus.overrun, W_0101);
      end
   endtask

   task automatic test_reset_midword();
      do_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, i == 0, 1'($urandom), 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (bus.dout_valid !== 1'b1 || bus.overrun !== 1'b1 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midword_setup: got valid=%b ovr=%b busy=%b, expected 1 1 1",
                  bus.dout_valid, bus.overrun, bus.busy);
      end
      #2;
      async_rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.dout !== 4'b0000 || bus.dout_valid !== 1'b0 || bus.overrun !== 1'b0 ||
          bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midword_reset: got dout=%b valid=%b ovr=%b busy=%b, expected all 0",
                  bus.dout, bus.dout_valid, bus.overrun, bus.busy);
      end
      model_clear();
      async_rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b0, 1'($urandom), 1'b1, 1'b0);
         n_cmp++;
         if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_ignore[%0d]: got valid=%b busy=%b, expected 0 0",
                     i, bus.dout_valid, bus.busy);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(9, 0) < 7, $urandom_range(9, 0) == 0, 1'($urandom),
               1'($urandom), $urandom_range(9, 0) == 0);
         n_cmp++;
         if (bus.dout_valid !== m_valid || bus.overrun !== m_ovr ||
             bus.busy !== (mq.size() != 0) || (m_valid && bus.dout !== m_dout)) begin
            n_fail++;
            $display("FAIL random[%0d]: got valid=%b ovr=%b busy=%b dout=%b, expected %b %b %b %b",
                     i, bus.dout_valid, bus.overrun, bus.busy, bus.dout,
                     m_valid, m_ovr, mq.size() != 0, m_dout);
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_idle_ignore();
      test_single_word();
      test_back_to_back(1'b1);
      test_back_to_back(1'b0);
      test_resync(1'b0);
      test_resync(1'b1);
      test_reset_midword();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
